// File: rtl/neuron_mac_seq_if.sv
// Handshake, weight-RAM read and result bundle for neuron_mac_seq.
// The neuron itself connects through the slave modport.
interface neuron_mac_seq_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned ACT_W  = 8,
    parameter int unsigned W_W    = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*ACT_W-1:0]      in_act;
    logic                    ram_read_en;
    logic [ADDR_W-1:0]       ram_read_addr;
    logic [W_W-1:0]          ram_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [15:0]      out_sum;
    logic                    out_spike;

    modport slave (
        input  in_valid, in_act, ram_data, out_ready,
        output in_ready, ram_read_en, ram_read_addr, out_valid, out_sum, out_spike
    );

    modport master (
        output in_valid, in_act, ram_data, out_ready,
        input  in_ready, ram_read_en, ram_read_addr, out_valid, out_sum, out_spike
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// One neuron evaluation per transaction: latches N activations, streams N weights from the
// parameter RAM, multiply-accumulates, then presents a saturated Q-shifted sum and spike flag.
module neuron_mac_seq #(
    parameter int unsigned        N      = 8,
    parameter int unsigned        ADDR_W = 3,
    parameter int unsigned        ACT_W  = 8,
    parameter int unsigned        W_W    = 16,
    parameter int unsigned        FRAC   = 8,
    parameter logic signed [15:0] THRESH = 16'sd4
) (
    input logic               clk,
    input logic               rst,
    neuron_mac_seq_if.slave   bus
);
    localparam int unsigned PROD_W = ACT_W + W_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(N);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [N-1:0][ACT_W-1:0]   act_q;
    logic [ADDR_W-1:0]         idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   acc_sum_c;
    logic signed [ACC_W-1:0]   acc_shr_c;
    logic signed [15:0]        sat_c;
    logic signed [15:0]        out_sum_q;
    logic                      out_spike_q;
    logic                      last_c;

    // Datapath: product of current weight and activation, running sum, output scaling.
    assign last_c    = (idx == ADDR_W'(N - 1));
    assign prod_c    = PROD_W'($signed(bus.ram_data)) * PROD_W'($signed(act_q[idx]));
    assign acc_sum_c = acc + ACC_W'(prod_c);
    assign acc_shr_c = acc_sum_c >>> FRAC;

    always_comb begin
        sat_c = acc_shr_c[15:0];
        if (acc_shr_c > SAT_MAX) begin
            sat_c = 16'sh7FFF;
        end else if (acc_shr_c < SAT_MIN) begin
            sat_c = 16'sh8000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded handshake/RAM controls.
    always_comb begin
        state_next        = state;
        bus.in_ready      = 1'b0;
        bus.ram_read_en   = 1'b0;
        bus.out_valid     = 1'b0;
        bus.ram_read_addr = idx;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = ACC;
            end
            ACC: begin
                bus.ram_read_en = 1'b1;
                if (last_c) state_next = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q       <= '0;
            acc         <= '0;
            idx         <= '0;
            out_sum_q   <= '0;
            out_spike_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        act_q <= bus.in_act;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_sum_c;
                    idx <= idx + ADDR_W'(1);
                    if (last_c) begin
                        out_sum_q   <= sat_c;
                        out_spike_q <= (sat_c >= THRESH);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_spike = out_spike_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed table, backpressure, mid-op reset and
// randomized transactions against a plain-arithmetic reference model.
module tb_neuron_mac_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [127:0] wts_cur;

    always #5 clk = ~clk;

    neuron_mac_seq_if #(.N(8), .ADDR_W(3), .ACT_W(8), .W_W(16)) bus ();

    neuron_mac_seq #(
        .N(8), .ADDR_W(3), .ACT_W(8), .W_W(16), .FRAC(8), .THRESH(16'sd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational weight RAM
    always_comb bus.ram_data = wts_cur[int'(bus.ram_read_addr)*16 +: 16];

    typedef struct {
        string              name;
        logic [127:0]       wts;
        logic [63:0]        acts;
        int                 hold;
        logic signed [15:0] exp_sum;
        logic               exp_spike;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input logic [127:0] w, input logic [63:0] a,
                                  output logic signed [15:0] s, output logic sp);
        longint sum = 0;
        for (int i = 0; i < 8; i++)
            sum += longint'($signed(w[i*16 +: 16])) * longint'($signed(a[i*8 +: 8]));
        sum = sum >>> 8;
        if (sum > 32767)       s = 16'sh7FFF;
        else if (sum < -32768) s = 16'sh8000;
        else                   s = 16'(sum);
        sp = (s >= 16'sd4);
    endfunction

    // Full transaction; called #1 after a rising edge with the DUT idle.
    task automatic run_txn(input logic [63:0] a, input int hold,
                           output logic signed [15:0] s, output logic sp);
        int seq_err = 0;
        int bp_err  = 0;
        int wait_c  = 0;
        logic signed [15:0] s0;
        logic sp0;
        chk("in_ready_idle", longint'(bus.in_ready), 1);
        if (bus.ram_read_en !== 1'b0) seq_err++;
        bus.in_valid = 1'b1;
        bus.in_act   = a;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_act   = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) begin
            if (bus.ram_read_en !== 1'b1 || bus.ram_read_addr !== 3'(k) ||
                bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) seq_err++;
            @(posedge clk); #1;
        end
        if (bus.ram_read_en !== 1'b0) seq_err++;
        chk("acc_sequence_errs", seq_err, 0);
        chk("latency_out_valid", longint'(bus.out_valid), 1);
        while (bus.out_valid !== 1'b1 && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        if (bus.out_valid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 28 cycles");
            s  = 'x;
            sp = 'x;
            return;
        end
        s0  = bus.out_sum;
        sp0 = bus.out_spike;
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_act   = {$urandom, $urandom};
            @(posedge clk); #1;
            if (bus.out_sum !== s0 || bus.out_spike !== sp0 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bp_err++;
        end
        if (hold > 0) chk("backpressure_errs", bp_err, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_hs", longint'(bus.in_ready), 1);
        chk("out_valid_after_hs", longint'(bus.out_valid), 0);
        s  = s0;
        sp = sp0;
    endtask

    initial begin
        vec_t               tbl[6];
        logic signed [15:0] s;
        logic               sp;
        logic signed [15:0] es;
        logic               esp;
        int                 stray;

        tbl[0] = '{"ones",        {8{16'h0100}}, {8{8'h01}}, 5, 16'sd8,      1'b1};
        tbl[1] = '{"mixed",       {8{16'h0100}}, {8'h04,8'h00,8'hFD,8'h03,8'hFE,8'h02,8'hFF,8'h01}, 0, 16'sd4, 1'b1};
        tbl[2] = '{"mixed_a7_3",  {8{16'h0100}}, {8'h03,8'h00,8'hFD,8'h03,8'hFE,8'h02,8'hFF,8'h01}, 2, 16'sd3, 1'b0};
        tbl[3] = '{"pos_sat",     {8{16'h7FFF}}, {8{8'h7F}}, 1, 16'sh7FFF,   1'b1};
        tbl[4] = '{"neg_sat",     {8{16'h8000}}, {8{8'h7F}}, 0, 16'sh8000,   1'b0};
        tbl[5] = '{"zero_wts",    {8{16'h0000}}, {8{8'h55}}, 0, 16'sd0,      1'b0};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.out_ready = 1'b0;
        wts_cur       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        chk("rst_ram_en",    longint'(bus.ram_read_en), 0);
        chk("rst_ram_addr",  longint'(bus.ram_read_addr), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_sum",   longint'(bus.out_sum), 0);
        chk("rst_out_spike", longint'(bus.out_spike), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            wts_cur = tbl[i].wts;
            run_txn(tbl[i].acts, tbl[i].hold, s, sp);
            chk({tbl[i].name, "_sum"},   longint'(s),  longint'(tbl[i].exp_sum));
            chk({tbl[i].name, "_spike"}, longint'(sp), longint'(tbl[i].exp_spike));
        end

        // Reset while the fourth weight is being read
        wts_cur = {8{16'h0100}};
        bus.in_valid = 1'b1;
        bus.in_act   = {8{8'h01}};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midop_addr_before_rst", longint'(bus.ram_read_addr), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midop_ram_en",    longint'(bus.ram_read_en), 0);
        chk("midop_out_valid", longint'(bus.out_valid), 0);
        chk("midop_in_ready",  longint'(bus.in_ready), 1);
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.ram_read_en !== 1'b0) stray++;
        end
        chk("midop_no_stray_result", stray, 0);
        run_txn({8{8'h01}}, 0, s, sp);
        chk("post_rst_sum",   longint'(s),  8);
        chk("post_rst_spike", longint'(sp), 1);

        // Randomized transactions against the reference model
        for (int r = 0; r < 24; r++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) begin
                if (r % 2 == 0) wts_cur[i*16 +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
                else            wts_cur[i*16 +: 16] = 16'($urandom);
            end
            model(wts_cur, a, es, esp);
            run_txn(a, int'($urandom_range(0, 3)), s, sp);
            chk("rand_sum",   longint'(s),  longint'(es));
            chk("rand_spike", longint'(sp), longint'(esp));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
